// File: rtl/kernel_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : kernel_window_gen                                               |
// | Function : Sliding 1-D pixel window generator. Pixels stream in, and each  |
// |            window of KERNEL_LEN consecutive pixels from the same line is   |
// |            emitted as one packed word. Lane 0 holds the oldest pixel.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module kernel_window_gen #(
  parameter int KERNEL_LEN = 8,
  parameter int I_OPP_W    = 8,
  parameter int LINE_W     = 640
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [I_OPP_W-1:0]            pix_in,
  input  logic                          pix_valid,
  input  logic                          pix_sol,
  output logic                          pix_ready,
  output logic [I_OPP_W*KERNEL_LEN-1:0] x,
  output logic                          x_valid,
  input  logic                          x_ready,
  output logic                          x_eol
);

  localparam int FILL_W = $clog2(KERNEL_LEN + 1);
  localparam int COL_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int WIN_W  = I_OPP_W * KERNEL_LEN;

  localparam logic [FILL_W-1:0] C_FULL     = FILL_W'(KERNEL_LEN);
  localparam logic [COL_W-1:0]  C_LAST_COL = COL_W'(LINE_W - 1);

  // FILL: fewer than KERNEL_LEN pixels of the current line held.
  // STREAM: the shift register holds a complete window.
  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WIN_W-1:0]    r_sr;
  logic [WIN_W-1:0]    w_sr_next;
  logic [FILL_W-1:0]   r_fill;
  logic [FILL_W-1:0]   w_fill_inc;
  logic [FILL_W-1:0]   w_fill_next;
  logic [COL_W-1:0]    r_col;
  logic [COL_W-1:0]    w_col_eff;
  logic [COL_W-1:0]    w_col_next;
  logic                w_accept;
  logic                w_is_last;
  logic                w_load;
  logic [WIN_W-1:0]    r_x;
  logic                r_x_valid;
  logic                r_x_eol;

  // Accept whenever the output register is empty or being drained this cycle.
  assign pix_ready = !r_x_valid || x_ready;
  assign w_accept  = pix_valid && pix_ready;

  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign x_eol   = r_x_eol;

  // Shift register next value: every lane moves one step towards lane 0,
  // the incoming pixel lands in the newest lane.
  always_comb begin
    w_sr_next = r_sr;
    for (int i = 0; i < KERNEL_LEN - 1; i++) begin
      w_sr_next[i*I_OPP_W +: I_OPP_W] = r_sr[(i+1)*I_OPP_W +: I_OPP_W];
    end
    w_sr_next[(KERNEL_LEN-1)*I_OPP_W +: I_OPP_W] = pix_in;
  end

  // Next-state and counter logic. A start-of-line pixel is column 0 and
  // restarts the fill, so stale lanes are never part of an emitted window;
  // the last column of a line clears fill so no window straddles two lines.
  always_comb begin
    w_col_eff    = pix_sol ? '0 : r_col;
    w_is_last    = (w_col_eff == C_LAST_COL);
    w_fill_next  = r_fill;
    w_col_next   = r_col;
    w_load       = 1'b0;
    if (pix_sol) begin
      w_fill_inc = FILL_W'(1);
    end else if (r_state == ST_STREAM) begin
      w_fill_inc = C_FULL;
    end else begin
      w_fill_inc = r_fill + FILL_W'(1);
    end
    if (w_accept) begin
      w_load      = (w_fill_inc == C_FULL);
      w_fill_next = w_is_last ? '0 : w_fill_inc;
      w_col_next  = w_is_last ? '0 : (w_col_eff + COL_W'(1));
    end
    w_state_next = (w_fill_next == C_FULL) ? ST_STREAM : ST_FILL;
  end

  // State, fill and column registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_FILL;
      r_fill  <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_next;
      r_fill  <= w_fill_next;
      r_col   <= w_col_next;
    end
  end

  // Pixel shift register advances only on an accepted pixel.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sr <= '0;
    end else if (w_accept) begin
      r_sr <= w_sr_next;
    end
  end

  // Output window register: load a completed window, otherwise hold until
  // the consumer takes it. A load can only happen when the register is free.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_x       <= '0;
      r_x_valid <= 1'b0;
      r_x_eol   <= 1'b0;
    end else if (w_load) begin
      r_x       <= w_sr_next;
      r_x_valid <= 1'b1;
      r_x_eol   <= w_is_last;
    end else if (x_ready) begin
      r_x_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kernel_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_kernel_window_gen                                            |
// | Function : Self-checking bench for kernel_window_gen (K=3, 8-bit, L=5).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_kernel_window_gen;

  localparam int K  = 3;
  localparam int W  = 8;
  localparam int L  = 5;
  localparam int NLINES = 400;

  logic          clk;
  logic          aresetn;
  logic [W-1:0]  pix_in;
  logic          pix_valid;
  logic          pix_sol;
  logic          pix_ready;
  logic [W*K-1:0] x;
  logic          x_valid;
  logic          x_ready;
  logic          x_eol;

  int n_cmp = 0;
  int n_bad = 0;

  kernel_window_gen #(.KERNEL_LEN(K), .I_OPP_W(W), .LINE_W(L)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sol   (pix_sol),
    .pix_ready (pix_ready),
    .x         (x),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_eol     (x_eol)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        sol;
    logic        xr;
    logic [7:0]  pix;
    logic        exp_pr;
    logic        exp_xv;
    logic [23:0] exp_x;
    logic        exp_eol;
  } vec_t;

  typedef struct {
    logic [23:0] x;
    logic        eol;
  } win_t;

  vec_t       tbl[$];
  win_t       expq[$];
  logic [7:0] pixq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic sol, input logic xr, input logic [7:0] pix,
                     input logic pr, input logic xv, input logic [23:0] ex, input logic eol);
    vec_t r;
    r.v = v; r.sol = sol; r.xr = xr; r.pix = pix;
    r.exp_pr = pr; r.exp_xv = xv; r.exp_x = ex; r.exp_eol = eol;
    tbl.push_back(r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    #2;
    chk("rst_x", 32'(x), 32'h0);
    chk("rst_x_valid", 32'(x_valid), 32'h0);
    chk("rst_x_eol", 32'(x_eol), 32'h0);
    chk("rst_pix_ready", 32'(pix_ready), 32'h1);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic feed(input logic [7:0] p, input logic xr);
    @(negedge clk);
    pix_valid = 1'b1; pix_sol = 1'b0; pix_in = p; x_ready = xr;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    aresetn = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_sol = 1'b0; x_ready = 1'b0;
    #3;
    chk("por_x", 32'(x), 32'h0);
    chk("por_x_valid", 32'(x_valid), 32'h0);
    chk("por_pix_ready", 32'(pix_ready), 32'h1);
    @(negedge clk);
    aresetn = 1'b1;

    // Two back-to-back lines 1..5, 6..10
    add(1,0,1,8'h01, 1,0,24'h0,0);
    add(1,0,1,8'h02, 1,0,24'h0,0);
    add(1,0,1,8'h03, 1,1,24'h030201,0);
    add(1,0,1,8'h04, 1,1,24'h040302,0);
    add(1,0,1,8'h05, 1,1,24'h050403,1);
    add(1,0,1,8'h06, 1,0,24'h0,0);
    add(1,0,1,8'h07, 1,0,24'h0,0);
    add(1,0,1,8'h08, 1,1,24'h080706,0);
    add(1,0,1,8'h09, 1,1,24'h090807,0);
    add(1,0,1,8'h0A, 1,1,24'h0A0908,1);
    add(0,0,1,8'h00, 1,0,24'h0,0);
    // Backpressure: first window held for four cycles
    add(1,0,0,8'h01, 1,0,24'h0,0);
    add(1,0,0,8'h02, 1,0,24'h0,0);
    add(1,0,0,8'h03, 1,1,24'h030201,0);
    for (int i = 0; i < 4; i++) add(1,0,0,8'h04, 0,1,24'h030201,0);
    add(1,0,1,8'h04, 1,1,24'h040302,0);
    add(1,0,1,8'h05, 1,1,24'h050403,1);
    add(0,0,1,8'h00, 1,0,24'h0,0);
    // Mid-line resync on pixel 9
    add(1,0,1,8'h07, 1,0,24'h0,0);
    add(1,0,1,8'h08, 1,0,24'h0,0);
    add(1,1,1,8'h09, 1,0,24'h0,0);
    add(1,0,1,8'h0A, 1,0,24'h0,0);
    add(1,0,1,8'h0B, 1,1,24'h0B0A09,0);
    add(1,0,1,8'h0C, 1,1,24'h0C0B0A,0);
    add(1,0,1,8'h0D, 1,1,24'h0D0C0B,1);
    add(0,0,1,8'h00, 1,0,24'h0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      pix_valid = tbl[i].v; pix_sol = tbl[i].sol; x_ready = tbl[i].xr; pix_in = tbl[i].pix;
      #1;
      chk($sformatf("pix_ready[%0d]", i), 32'(pix_ready), 32'(tbl[i].exp_pr));
      @(posedge clk);
      #1;
      chk($sformatf("x_valid[%0d]", i), 32'(x_valid), 32'(tbl[i].exp_xv));
      if (tbl[i].exp_xv) begin
        chk($sformatf("x[%0d]", i), 32'(x), 32'(tbl[i].exp_x));
        chk($sformatf("x_eol[%0d]", i), 32'(x_eol), 32'(tbl[i].exp_eol));
      end
    end
    pix_valid = 1'b0; pix_sol = 1'b0;

    // Reset mid-line with a held window, then 5,6,7 from column 0
    do_reset();
    feed(8'h01, 1'b0);
    feed(8'h02, 1'b0);
    feed(8'h03, 1'b0);
    chk("pre_rst_x", 32'(x), 32'h030201);
    do_reset();
    feed(8'h05, 1'b1);
    feed(8'h06, 1'b1);
    chk("post_rst_no_win", 32'(x_valid), 32'h0);
    feed(8'h07, 1'b1);
    chk("post_rst_xv", 32'(x_valid), 32'h1);
    chk("post_rst_x", 32'(x), 32'h070605);
    chk("post_rst_eol", 32'(x_eol), 32'h0);

    // Random handshake traffic against a per-line sliding-window reference
    do_reset();
    for (int ln = 0; ln < NLINES; ln++) begin
      for (int p = 0; p < L; p++) pixq.push_back(8'($urandom));
      for (int w = 0; w <= L - K; w++) begin
        win_t e;
        e.x   = {pixq[ln*L + w + 2], pixq[ln*L + w + 1], pixq[ln*L + w]};
        e.eol = (w == L - K);
        expq.push_back(e);
      end
    end
    begin
      int idx = 0;
      int cyc = 0;
      int total = NLINES * L;
      logic pr, xv, xe;
      logic [23:0] xx;
      while ((idx < total || expq.size() != 0) && cyc < 40000) begin
        @(negedge clk);
        pix_valid = (idx < total) ? 1'($urandom_range(0, 1)) : 1'b0;
        pix_in    = (idx < total) ? pixq[idx] : 8'($urandom);
        pix_sol   = 1'($urandom_range(0, 1)) & ~pix_valid;
        x_ready   = 1'($urandom_range(0, 1));
        #1;
        pr = pix_ready; xv = x_valid; xx = x; xe = x_eol;
        if (xv && x_ready) begin
          if (expq.size() == 0) begin
            chk("rnd_extra_window", 32'(xx), 32'hFFFFFFFF);
          end else begin
            win_t e;
            e = expq.pop_front();
            chk("rnd_x", 32'(xx), 32'(e.x));
            chk("rnd_eol", 32'(xe), 32'(e.eol));
          end
        end
        @(posedge clk);
        if (pix_valid && pr) idx++;
        cyc++;
      end
      chk("rnd_pixels_taken", 32'(idx), 32'(total));
      chk("rnd_windows_left", 32'(expq.size()), 32'h0);
    end
    pix_valid = 1'b0; pix_sol = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
